seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//   Multi-cycle restoring divider for RV64M DIV/DIVU/REM/REMU. It is the inverse companion of
//   the combinational add/sub datapath: it performs one trial subtract per cycle instead of a
//   single-cycle add. It sits beside the ALU in the execute stage. The control FSM stalls on
//   busy and captures result when done pulses.
// PARAMETERS
//   XLEN   64   operand/result width in bits; must be >= 4 and a power of two
// PORTS
//   clk       in   1     system clock, rising-edge
//   rst_n     in   1     asynchronous active-low reset
//   start     in   1     request; sampled only when busy==0
//   op        in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend  in   XLEN  rs1 value, sampled with start
//   divisor   in   XLEN  rs2 value, sampled with start
//   busy      out  1     operation in progress (PREP/ITER/FIX)
//   done      out  1     one-cycle pulse; result valid this cycle
//   result    out  XLEN  quotient or remainder; held until the next done
// BEHAVIOUR
//   Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
//   Reset: state=IDLE, busy=0, done=0, result=0, all internal registers 0; takes effect
//     immediately, including mid-operation; the in-flight operation is discarded and no done fires.
//   FSM: IDLE -> PREP -> ITER (XLEN cycles) -> FIX -> DONE -> IDLE.
//     Also DONE -> PREP when start=1 in DONE (back-to-back accepted).
//   Handshake: start accepted on an edge where state is IDLE or DONE; operands/op latched then.
//     start while busy==1 is ignored; no queuing; latched operands are unaffected.
//   Latency: fixed. With start accepted on edge E, done=1 in the cycle after edge E+XLEN+2.
//     This holds for every op, including special cases. busy=1 from after E through edge E+XLEN+2.
//   PREP: signed ops (DIV/REM): take abs of both operands; record quotient sign
//     (sign(dividend) XOR sign(divisor)) and remainder sign (sign(dividend)).
//     Unsigned ops use the raw operands. Load rem=0, quo=|dividend|, cnt=XLEN.
//   ITER (per cycle): shift {rem,quo} left 1; trial = rem_shifted - |divisor| in XLEN+1 bits.
//     If trial >= 0: rem=trial[XLEN-1:0], quo[0]=1. Otherwise restore, quo[0]=0. Then cnt-1.
//     Leave ITER when cnt reaches 0 after the XLEN-th iteration.
//   FIX: negate quo/rem per the recorded signs (two's complement, wrap modulo 2^XLEN), then
//     select by op[1]: 0 = quotient, 1 = remainder. Register into result.
//   Special cases (resolved in FIX; override the iterative value):
//     divisor==0: DIV/DIVU -> all ones; REM/REMU -> dividend (original, unsigned bits).
//     DIV, dividend==-2^(XLEN-1), divisor==-1: quotient = dividend; REM of same = 0.
//   Remainder sign always follows the dividend; quotient truncates toward zero.
//   DONE: done=1 for exactly this cycle. Next state is IDLE, or PREP if start=1.
//   result changes only on the edge entering DONE.
// TESTING
//   1 DIVU 100/7 -> done after XLEN+2 edges, result=14; busy high the whole time, then low.
//   2 REM -7/2 -> result=-1 (0xFFFF_FFFF_FFFF_FFFF); DIV -7/2 -> -3; REMU 7/0 -> 7.
//   3 DIV 5/0 -> all ones; DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000;
//     REM of the same operands -> 0.
//   4 start=1 held with new operands during busy -> ignored; result from first op only,
//     single done pulse.
//   5 rst_n low at ITER cycle 20 -> busy/done/result 0 at once; no done follows; a new op
//     completes correctly.
//   6 back-to-back: start asserted in the DONE cycle -> second op accepted, its done after
//     exactly XLEN+2 further edges.

Source files
------------

// File: rtl/seq_divider.sv
// Restoring divider for RV64M DIV/DIVU/REM/REMU, one trial subtract per cycle; done arrives XLEN+2 edges after accept.
// start is accepted only in IDLE or DONE; a start seen while busy is dropped (no queuing, no backpressure on result).
module seq_divider #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] ZERO  = '0;
    localparam logic [XLEN-1:0] ONES  = '1;
    localparam logic [XLEN-1:0] MIN_S = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            signed_op;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    logic            ovf;

    // op[0]=0 selects the signed variants (DIV/REM)
    assign signed_op = ~op_q[0];
    assign a_neg     = signed_op & a_q[XLEN-1];
    assign b_neg     = signed_op & b_q[XLEN-1];
    assign rem_sh    = {rem_q, quo_q[XLEN-1]};
    assign trial     = rem_sh - {1'b0, dvs_q};
    assign q_fix     = qneg_q ? (ZERO - quo_q) : quo_q;
    assign r_fix     = rneg_q ? (ZERO - rem_q) : rem_q;
    assign ovf       = signed_op && (a_q == MIN_S) && (b_q == ONES);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_PREP;
                    op_d    = op;
                    a_d     = dividend;
                    b_d     = divisor;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PREP: begin
                state_d = S_ITER;
                rem_d   = ZERO;
                quo_d   = a_neg ? (ZERO - a_q) : a_q;
                dvs_d   = b_neg ? (ZERO - b_q) : b_q;
                cnt_d   = CW'(XLEN);
                qneg_d  = a_neg ^ b_neg;
                rneg_d  = a_neg;
            end
            S_ITER: begin
                // trial[XLEN] set means the subtract underflowed: keep the shifted remainder
                if (!trial[XLEN]) begin
                    rem_d = trial[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_DONE;
                if (b_q == ZERO) begin
                    result_d = op_q[1] ? a_q : ONES;
                end else if (ovf) begin
                    result_d = op_q[1] ? ZERO : a_q;
                end else begin
                    result_d = op_q[1] ? r_fix : q_fix;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= 2'b00;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == S_PREP) || (state_q == S_ITER) || (state_q == S_FIX);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_seq_divider.sv
// Randomized bench for seq_divider against a plain-arithmetic RV64M reference.
module tb_seq_divider;
    localparam int XLEN = 64;
    localparam logic [XLEN-1:0] MIN_S = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES  = '1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [1:0]      op = 2'b00;
    logic [XLEN-1:0] dividend = '0;
    logic [XLEN-1:0] divisor = '0;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_divider #(.XLEN(XLEN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] model(input logic [1:0] o, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        longint sa;
        longint sb;
        logic [XLEN-1:0] r;
        sa = a;
        sb = b;
        case (o)
            2'b00:   r = (b == 0) ? ONES : ((a == MIN_S && b == ONES) ? a : XLEN'(sa / sb));
            2'b01:   r = (b == 0) ? ONES : a / b;
            2'b10:   r = (b == 0) ? a : ((a == MIN_S && b == ONES) ? '0 : XLEN'(sa % sb));
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Called at a negedge; leaves the bench at the negedge of the done cycle.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input bit junk, output logic [XLEN-1:0] exp);
        int bad;
        exp      = model(o, a, b);
        start    = 1'b1;
        op       = o;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        bad = 0;
        for (int j = 0; j <= XLEN + 1; j++) begin
            if (junk && j < XLEN) begin
                start    = 1'b1;
                op       = 2'($urandom);
                dividend = {$urandom, $urandom};
                divisor  = {$urandom, $urandom};
            end else begin
                start = 1'b0;
            end
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            @(negedge clk);
        end
        check({tag, " busy_window"}, XLEN'(bad), '0);
        check({tag, " done"}, XLEN'(done), 1);
        check({tag, " busy_low"}, XLEN'(busy), 0);
        check({tag, " result"}, result, exp);
    endtask

    task automatic idle_chk(input string tag, input logic [XLEN-1:0] exp);
        start = 1'b0;
        @(negedge clk);
        check({tag, " done_fall"}, XLEN'(done), 0);
        check({tag, " hold"}, result, exp);
    endtask

    initial begin
        logic [XLEN-1:0] e;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [1:0]      o;
        int              n_done;

        repeat (2) @(negedge clk);
        check("rst busy", XLEN'(busy), 0);
        check("rst done", XLEN'(done), 0);
        check("rst result", result, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("divu_100_7", 2'b01, 100, 7, 1'b0, e);
        check("divu_100_7 lit", result, 14);
        idle_chk("divu_100_7", e);
        do_op("rem_m7_2", 2'b10, -64'sd7, 2, 1'b0, e);
        check("rem_m7_2 lit", result, ONES);
        idle_chk("rem_m7_2", e);
        do_op("div_m7_2", 2'b00, -64'sd7, 2, 1'b0, e);
        check("div_m7_2 lit", result, -64'sd3);
        idle_chk("div_m7_2", e);
        do_op("remu_7_0", 2'b11, 7, 0, 1'b0, e);
        check("remu_7_0 lit", result, 7);
        idle_chk("remu_7_0", e);
        do_op("div_5_0", 2'b00, 5, 0, 1'b0, e);
        check("div_5_0 lit", result, ONES);
        idle_chk("div_5_0", e);
        do_op("div_ovf", 2'b00, MIN_S, ONES, 1'b0, e);
        check("div_ovf lit", result, MIN_S);
        idle_chk("div_ovf", e);
        do_op("rem_ovf", 2'b10, MIN_S, ONES, 1'b0, e);
        check("rem_ovf lit", result, 0);
        idle_chk("rem_ovf", e);

        do_op("junk_start", 2'b00, 1000, -64'sd3, 1'b1, e);
        check("junk_start lit", result, -64'sd333);
        idle_chk("junk_start", e);

        do_op("b2b_first", 2'b01, 123456789, 1000, 1'b0, e);
        do_op("b2b_second", 2'b11, 123456789, 1000, 1'b0, e);
        check("b2b_second lit", result, 789);
        idle_chk("b2b_second", e);

        // Reset in the 20th ITER cycle of an operation
        start    = 1'b1;
        op       = 2'b00;
        dividend = 64'h1234_5678_9ABC_DEF0;
        divisor  = 64'd12345;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("pre_rst busy", XLEN'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst busy", XLEN'(busy), 0);
        check("mid_rst done", XLEN'(done), 0);
        check("mid_rst result", result, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        repeat (XLEN + 6) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("no_done_after_rst", XLEN'(n_done), 0);
        do_op("post_rst", 2'b00, -64'sd100, 7, 1'b0, e);
        check("post_rst lit", result, -64'sd14);
        idle_chk("post_rst", e);

        for (int i = 0; i < 60; i++) begin
            o = 2'($urandom);
            a = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: b = {$urandom, $urandom};
                1: b = XLEN'($urandom_range(1, 255));
                2: b = '0;
                3: begin a = MIN_S; b = ONES; end
                4: begin a = -XLEN'($urandom_range(0, 100000)); b = -XLEN'($urandom_range(1, 50)); end
                default: begin a = XLEN'($urandom); b = {1'b0, {(XLEN-1){1'b1}}} - XLEN'($urandom); end
            endcase
            do_op($sformatf("rnd%0d", i), o, a, b, bit'($urandom_range(0, 3) == 0), e);
            if ($urandom_range(0, 1) == 1) idle_chk($sformatf("rnd%0d", i), e);
        end
        idle_chk("final", e);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
